// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a length-prefixed, XOR-checksummed byte stream
// big-endian into 32-bit words and writes them while holding the CPU in stall.
module imem_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_len,
    output logic              err_chk,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [7:0]       DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0]  WC_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_e;

    state_e            state_q;
    logic              ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              hold_q;
    logic              done_q;
    logic              err_len_q;
    logic              err_chk_q;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W:0]   wc_d;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        idx_q;
    logic [23:0]       shift_q;
    logic [7:0]        xsum_q;
    logic              accept;

    assign accept = byte_valid && ready_q;
    assign wc_d   = wc_q + WC_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            wc_q      <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            xsum_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            // ready stays low for one cycle after start so a byte presented
            // alongside start is never taken as the length header
            if (start) begin
                state_q   <= S_LEN;
                ready_q   <= 1'b0;
                hold_q    <= 1'b1;
                err_len_q <= 1'b0;
                err_chk_q <= 1'b0;
                wc_q      <= '0;
                len_q     <= '0;
                idx_q     <= '0;
                xsum_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: ready_q <= 1'b0;
                    S_LEN: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            xsum_q <= xsum_q ^ byte_data;
                            if (byte_data == 8'd0 || byte_data > DEPTH_B) begin
                                err_len_q <= 1'b1;
                                ready_q   <= 1'b0;
                                state_q   <= S_IDLE;
                            end else begin
                                len_q   <= byte_data[ADDR_W:0];
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            shift_q <= {shift_q[15:0], byte_data};
                            xsum_q  <= xsum_q ^ byte_data;
                            idx_q   <= idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                ready_q   <= 1'b0;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= wc_q[ADDR_W-1:0];
                                wr_data_q <= {shift_q, byte_data};
                                state_q   <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        ready_q <= 1'b1;
                        wc_q    <= wc_d;
                        state_q <= (wc_d == len_q) ? S_CHK : S_DATA;
                    end
                    S_CHK: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            ready_q <= 1'b0;
                            state_q <= S_IDLE;
                            if (byte_data == xsum_q) begin
                                done_q <= 1'b1;
                                hold_q <= 1'b0;
                            end else begin
                                err_chk_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        ready_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign byte_ready = ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err_len    = err_len_q;
    assign err_chk    = err_chk_q;
    assign word_count = wc_q;

endmodule
